// File: rtl/bias_startup_ctrl.sv
// Control sequencer for the EG1D80V bias/bandgap cell: startup pulse,
// trim capture, valid qualification, VBIAS grant and fault reporting.
module bias_startup_ctrl #(
  parameter int STARTUP_CYCLES = 64,
  parameter int SETTLE_CYCLES  = 256,
  parameter int TIMEOUT_CYCLES = 1024,
  parameter int CNT_W          = 11
) (
  input  logic       CLK_I,
  input  logic       RST_N_I,
  input  logic       REQ_I,
  input  logic       VBIAS_REQ_I,
  input  logic [3:0] TRIM_BIAS_CFG_I,
  input  logic [4:0] TRIM_CURV_CFG_I,
  input  logic [4:0] TRIM_VBG_CFG_I,
  input  logic       BG_VALID_N_I,
  output logic       EN_O,
  output logic       BG_STARTUP_O,
  output logic       EN_VBIAS_O,
  output logic [3:0] TRIM_BIAS_O,
  output logic [4:0] TRIM_CURV_O,
  output logic [4:0] TRIM_VBG_O,
  output logic       READY_O,
  output logic       FAULT_O,
  output logic [2:0] STATE_O
);

  typedef enum logic [2:0] {
    stOff     = 3'd0,
    stStartup = 3'd1,
    stSettle  = 3'd2,
    stReady   = 3'd3,
    stFault   = 3'd4
  } stateT;

  localparam logic [CNT_W-1:0] cntOne =
    CNT_W'(1);
  localparam logic [CNT_W-1:0] startupLast =
    CNT_W'(STARTUP_CYCLES - 1);
  localparam logic [CNT_W-1:0] stableLast =
    CNT_W'(SETTLE_CYCLES - 1);
  localparam logic [CNT_W-1:0] timeoutLast =
    CNT_W'(TIMEOUT_CYCLES - 1);

  stateT            state;
  stateT            stateNxt;
  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] cntNxt;
  logic [CNT_W-1:0] stabCnt;
  logic [CNT_W-1:0] stabNxt;
  logic             vnMeta;
  logic             vnS;
  logic             stableDone;
  logic             timedOut;
  logic             enNxt;
  logic             startupNxt;
  logic             readyNxt;
  logic             faultNxt;
  logic             vbiasNxt;

  // Valid flag is asynchronous; resets to invalid.
  always_ff @(posedge CLK_I or negedge RST_N_I) begin
    if (!RST_N_I) begin
      vnMeta <= 1'b1;
      vnS    <= 1'b1;
    end else begin
      vnMeta <= BG_VALID_N_I;
      vnS    <= vnMeta;
    end
  end

  assign stableDone = !vnS && (stabCnt == stableLast);
  assign timedOut   = (cnt == timeoutLast);

  always_comb begin
    stateNxt = state;
    cntNxt   = '0;
    stabNxt  = '0;
    unique case (state)
      stOff: begin
        if (REQ_I) stateNxt = stStartup;
      end
      stStartup: begin
        cntNxt = cnt + cntOne;
        if (cnt == startupLast) stateNxt = stSettle;
      end
      stSettle: begin
        cntNxt  = cnt + cntOne;
        stabNxt = vnS ? '0 : stabCnt + cntOne;
        // A tie between stability and timeout resolves to READY.
        if (stableDone) stateNxt = stReady;
        else if (timedOut) stateNxt = stFault;
      end
      stReady: begin
        if (vnS) stateNxt = stFault;
      end
      stFault: begin
        stateNxt = stFault;
      end
      default: begin
        stateNxt = stOff;
      end
    endcase
    if (!REQ_I) stateNxt = stOff;
    // Every state entry restarts both counters from zero.
    if (stateNxt != state) begin
      cntNxt  = '0;
      stabNxt = '0;
    end
  end

  always_comb begin
    enNxt      = 1'b0;
    startupNxt = 1'b0;
    readyNxt   = 1'b0;
    faultNxt   = 1'b0;
    vbiasNxt   = 1'b0;
    unique case (1'b1)
      (stateNxt == stStartup): begin
        enNxt      = 1'b1;
        startupNxt = 1'b1;
      end
      (stateNxt == stSettle): begin
        enNxt = 1'b1;
      end
      (stateNxt == stReady): begin
        enNxt    = 1'b1;
        readyNxt = 1'b1;
        vbiasNxt = VBIAS_REQ_I;
      end
      (stateNxt == stFault): begin
        faultNxt = 1'b1;
      end
      default: begin
        enNxt = 1'b0;
      end
    endcase
  end

  always_ff @(posedge CLK_I or negedge RST_N_I) begin
    if (!RST_N_I) begin
      state   <= stOff;
      cnt     <= '0;
      stabCnt <= '0;
    end else begin
      state   <= stateNxt;
      cnt     <= cntNxt;
      stabCnt <= stabNxt;
    end
  end

  // Outputs are registered from the next state so they align with STATE_O.
  always_ff @(posedge CLK_I or negedge RST_N_I) begin
    if (!RST_N_I) begin
      EN_O         <= 1'b0;
      BG_STARTUP_O <= 1'b0;
      EN_VBIAS_O   <= 1'b0;
      READY_O      <= 1'b0;
      FAULT_O      <= 1'b0;
    end else begin
      EN_O         <= enNxt;
      BG_STARTUP_O <= startupNxt;
      EN_VBIAS_O   <= vbiasNxt;
      READY_O      <= readyNxt;
      FAULT_O      <= faultNxt;
    end
  end

  // Trims track the config only while the cell is off.
  always_ff @(posedge CLK_I or negedge RST_N_I) begin
    if (!RST_N_I) begin
      TRIM_BIAS_O <= '0;
      TRIM_CURV_O <= '0;
      TRIM_VBG_O  <= '0;
    end else if (state == stOff) begin
      TRIM_BIAS_O <= TRIM_BIAS_CFG_I;
      TRIM_CURV_O <= TRIM_CURV_CFG_I;
      TRIM_VBG_O  <= TRIM_VBG_CFG_I;
    end
  end

  assign STATE_O = state;

endmodule

// File: doc/bias_startup_ctrl.md
# bias_startup_ctrl

Digital sequencer that drives the control side of the EG1D80V bias/bandgap IO cell. It powers the bandgap up with a timed startup pulse, applies trims, and qualifies the cell's active-low valid flag, which it synchronises and debounces. It then grants VBIAS drive to the core and reports ready or fault. It sits in the always-on domain next to the bias cell, and its outputs connect directly to the cell's EN/startup/trim/VBIAS-enable pins.

## Interface
- STARTUP_CYCLES, default 64: cycles BG_STARTUP_O is held high after enable (≥1).
- SETTLE_CYCLES, default 256: consecutive synchronised-valid cycles required before READY (≥1).
- TIMEOUT_CYCLES, default 1024: maximum cycles in SETTLE before FAULT; must exceed SETTLE_CYCLES+2.
- CNT_W, default 11: counter width; must hold max(STARTUP_CYCLES, TIMEOUT_CYCLES).
- CLK_I  in  1  clock.
- RST_N_I  in  1  reset; one clock, asynchronous, active-low.
- REQ_I  in  1  level request for bias on; low forces OFF.
- VBIAS_REQ_I  in  1  request VBIAS drive; honoured only in READY.
- TRIM_BIAS_CFG_I / TRIM_CURV_CFG_I / TRIM_VBG_CFG_I  in  4/5/5  trim configuration.
- BG_VALID_N_I  in  1  cell valid flag, active-low, asynchronous to CLK_I.
- EN_O  out  1  cell enable.
- BG_STARTUP_O  out  1  bandgap startup pulse.
- EN_VBIAS_O  out  1  VBIAS drive enable.
- TRIM_BIAS_O / TRIM_CURV_O / TRIM_VBG_O  out  4/5/5  trims to cell.
- READY_O  out  1  bias qualified.
- FAULT_O  out  1  startup timeout or valid lost.
- STATE_O  out  3  encoded state, for debug.

## Operation
- All outputs are registered. Reset values: EN_O=0, BG_STARTUP_O=0, EN_VBIAS_O=0, all trims=0, READY_O=0, FAULT_O=0, STATE_O=OFF.
- BG_VALID_N_I passes through a 2-flop synchroniser with reset value 1 (invalid); vn_s denotes the synchroniser output.
- States: OFF=0, STARTUP=1, SETTLE=2, READY=3, FAULT=4.
- OFF: EN_O=0, BG_STARTUP_O=0. The trim shadow registers load from the *_CFG_I inputs every cycle. REQ_I=1 moves to STARTUP. The trims are frozen in every other state.
- STARTUP: EN_O=1, BG_STARTUP_O=1. The counter starts at 0. After STARTUP_CYCLES cycles in this state, the block moves to SETTLE.
- SETTLE: EN_O=1, BG_STARTUP_O=0. stab_cnt increments while vn_s=0 and clears when vn_s=1. tmo_cnt increments every cycle from 0.
  - If vn_s=0 and stab_cnt=SETTLE_CYCLES-1, the block moves to READY.
  - Otherwise, if tmo_cnt=TIMEOUT_CYCLES-1, the block moves to FAULT.
  - If both conditions hold in the same cycle, READY wins.
- READY: EN_O=1, READY_O=1. EN_VBIAS_O is a registered copy of VBIAS_REQ_I. If vn_s=1, the block moves to FAULT.
- FAULT: EN_O=0, EN_VBIAS_O=0, FAULT_O=1. FAULT_O is sticky until the block exits to OFF. The block stays in FAULT while REQ_I=1.
- REQ_I=0 in any state has top priority and moves to OFF at the next edge. FAULT_O clears on that transition.
- Asserting reset mid-sequence returns all outputs to their reset values immediately. The synchroniser also resets.

## Timing
- REQ_I sampled high at edge t in OFF: EN_O=1 and BG_STARTUP_O=1 from t+1.
- BG_STARTUP_O is high for exactly STARTUP_CYCLES cycles, then falls. EN_O stays high.
- A change on BG_VALID_N_I is visible on vn_s 2 edges later.
- Earliest READY_O: SETTLE_CYCLES cycles after SETTLE entry, provided vn_s=0 throughout.
- In READY, EN_VBIAS_O follows VBIAS_REQ_I with 1 cycle of latency.
- Valid lost in READY: FAULT_O=1 and EN_O=0 three edges after BG_VALID_N_I rises (2 for the synchroniser, 1 for the state register). EN_VBIAS_O drops on the same edge.
- REQ_I deasserted: all outputs reach their OFF values 1 edge later.

## Test plan
Bench parameters: STARTUP_CYCLES=4, SETTLE_CYCLES=8, TIMEOUT_CYCLES=32.
- Nominal power-up:
  - Stimulus: trims 4'hA/5'h11/5'h05, REQ_I=1, BG_VALID_N_I=0 held from reset.
  - Expected: BG_STARTUP_O high for 4 cycles, then READY_O=1 8 cycles after SETTLE entry.
  - Expected: the trims read back unchanged. Setting VBIAS_REQ_I=1 gives EN_VBIAS_O=1 one cycle later.
- Trim freeze:
  - Stimulus: change the *_CFG_I inputs while in SETTLE and in READY.
  - Expected: the TRIM_*_O outputs do not change. New values appear only after a pass through OFF.
- Chattering valid:
  - Stimulus: in SETTLE, BG_VALID_N_I pulses high for 1 cycle after every 6 low cycles.
  - Expected: stab_cnt never reaches 8. FAULT_O=1 after 32 cycles in SETTLE, with EN_O=0.
- Valid lost:
  - Stimulus: in READY with EN_VBIAS_O=1, BG_VALID_N_I rises.
  - Expected: 3 edges later, FAULT_O=1, READY_O=0, EN_VBIAS_O=0, STATE_O=4.
  - Expected: FAULT_O stays 1 until REQ_I=0, then OFF and FAULT_O=0.
- Boundary tie:
  - Stimulus: valid goes low so the 8th consecutive valid cycle lands exactly on tmo_cnt=31.
  - Expected: the block enters READY, not FAULT.
- Abort:
  - Stimulus 1: REQ_I drops during STARTUP cycle 2. Expected: OFF next edge, BG_STARTUP_O=0.
  - Stimulus 2: RST_N_I asserted in READY. Expected: all outputs at reset values with no clock edge.
